reorder_buffer: RTL
===================

REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 Parameter DEPTH, default 16: number of ROB entries; robNum values 0..DEPTH-1 are valid.
REQ-002 Parameter INVALID_NUM, default 6'b010000: tag meaning "no producer / value ready".
REQ-003 clock  in  1  single clock; all state updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-low reset.
REQ-005 alloc_valid  in  1  request to allocate one entry this cycle.
REQ-006 alloc_dest  in  5  architectural destination register of the allocating instruction.
REQ-007 alloc_ready  out  1  combinational: 1 when count < DEPTH.
REQ-008 alloc_robNum  out  6  combinational: tail index; the tag given to the allocating instruction.
REQ-009 CDBiscast / CDBrobNum / CDBdata  in  1/6/32  result broadcast port 1.
REQ-010 CDBiscast2 / CDBrobNum2 / CDBdata2  in  1/6/32  result broadcast port 2.
REQ-011 index  in  6  operand lookup tag from a reservation station.
REQ-012 ready  out  1  combinational: the looked-up entry holds its result.
REQ-013 value  out  32  combinational: the looked-up entry's result.
REQ-014 commit_valid  out  1  registered one-cycle retire strobe.
REQ-015 commit_robNum / commit_dest / commit_data  out  6/5/32  registered retiring entry tag, destination, result.
REQ-016 flush  in  1  discard all in-flight entries.

Function
REQ-017 Entry state: busy, done, dest[4:0], data[31:0]; pointers head, tail (4 bits, wrap DEPTH-1 -> 0); count (5 bits, 0..16).
REQ-018 Allocation: alloc_valid & alloc_ready at an edge sets entry[tail] busy=1, done=0, dest=alloc_dest, then increments tail and count.
REQ-019 alloc_valid while full (count=16) is ignored; no state change; no error output.
REQ-020 CDB write: CDBiscast=1, CDBrobNum<DEPTH and entry busy at an edge sets done=1 and data=CDBdata; port 2 behaves identically.
REQ-021 CDB tag >= DEPTH, or tag naming a non-busy entry, is ignored.
REQ-022 Both ports naming the same tag in one cycle: port 1 data wins.
REQ-023 Lookup: index<DEPTH and entry busy & done -> ready=1, value=data.
REQ-024 Lookup bypass: same-cycle CDB port hit on index -> ready=1, value=CDB data, port 1 first.
REQ-025 Lookup otherwise (index>=DEPTH, non-busy, not done, no bypass) -> ready=0, value=0.
REQ-026 Commit: at an edge where entry[head] is busy & done, drive commit_valid=1 and commit_robNum=head, commit_dest, commit_data for one cycle.
REQ-027 Commit also clears entry[head].busy, increments head, and decrements count; at most one commit per cycle; commit_valid=0 in all other cycles.
REQ-028 Commit latency: a result written at edge N retires at edge N+1 at the earliest; in-order only, a done entry behind a not-done head waits.
REQ-029 Simultaneous allocate and commit: count is unchanged; alloc_ready is evaluated on the pre-edge count, so a full ROB refuses allocation even in a commit cycle.
REQ-030 Empty ROB with same-cycle alloc and CDB to the new tag: the CDB write is ignored because the entry is not yet busy.
REQ-031 Flush at an edge: all busy=0, done=0; head=tail=count=0; commit_valid=0; same-cycle alloc, CDB and commit are discarded.

Reset
REQ-032 reset=0 at an edge: all entries busy=0, done=0, data=0, dest=0; head=tail=count=0.
REQ-033 reset=0 at an edge: commit_valid=0, commit_robNum=INVALID_NUM, commit_dest=0, commit_data=0.
REQ-034 Reset has priority over flush, alloc, CDB and commit.
REQ-035 Reset asserted mid-operation discards all entries with no commit emitted.
REQ-036 After reset: alloc_ready=1, alloc_robNum=0.

Structure
REQ-037 Shared CPU package holds INVALID_NUM, ROB_DEPTH, and the robNum width (6); the reservation stations use the same constants.
REQ-038 Sub-module rob_lookup: combinational index/CDB bypass mux producing ready/value.

Verification
REQ-039 Reset, then allocate dest 3,4,5 -> alloc_robNum 0,1,2; count=3; no commit.
REQ-040 Broadcast tag 1 = 0x55, then tag 0 = 0x11 -> tag 0 commits (dest 3, 0x11) one edge later; tag 1 (dest 4, 0x55) commits the next edge.
REQ-041 Allocate 16 entries -> alloc_ready=0; 17th alloc ignored; complete tag 0 -> commit; alloc_robNum=0 wraps, alloc accepted next edge.
REQ-042 Lookup index 2 in the same cycle as CDB port 2 tag 2 = 0xABCD -> ready=1, value=0xABCD; index 16 -> ready=0, value=0.
REQ-043 Both CDB ports tag 0 (0x1 and 0x2) -> stored 0x1; flush with 5 entries -> count=0, no commit, next alloc_robNum=0.
REQ-044 reset=0 mid-stream with done head -> no commit_valid; commit_robNum=16.

Source files
------------

// File: rtl/reorder_buffer_pkg.sv
// Shared CPU constants and the result-broadcast payload used by the ROB and
// the reservation stations.
package reorder_buffer_pkg;

    localparam int unsigned ROB_DEPTH  = 16;
    localparam int unsigned ROB_NUM_W  = 6;
    localparam int unsigned ARCH_REG_W = 5;
    localparam int unsigned DATA_W     = 32;

    // Tag meaning "no producer / value ready"; one past the last valid entry.
    localparam logic [ROB_NUM_W-1:0] ROB_INVALID_NUM = 6'b010000;

    typedef struct packed {
        logic                 valid;
        logic [ROB_NUM_W-1:0] rob_num;
        logic [DATA_W-1:0]    data;
    } cdb_t;

endpackage

// File: rtl/rob_lookup.sv
// Operand lookup: returns a ROB entry's result for a reservation station,
// forwarding a same-cycle broadcast ahead of the stored value.
module rob_lookup
    import reorder_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = ROB_DEPTH
) (
    input  logic [ROB_NUM_W-1:0]         index,
    input  cdb_t                         cdb1,
    input  cdb_t                         cdb2,
    input  logic [DEPTH-1:0]             busy,
    input  logic [DEPTH-1:0]             done,
    input  logic [DEPTH-1:0][DATA_W-1:0] data,
    output logic                         ready,
    output logic [DATA_W-1:0]            value
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PTR_W-1:0] slot;

    assign slot = PTR_W'(index);

    // Port 1 beats port 2, and both beat the stored copy.
    always_comb begin
        ready = 1'b0;
        value = '0;
        if (index < ROB_NUM_W'(DEPTH)) begin
            if (cdb1.valid && (cdb1.rob_num == index)) begin
                ready = 1'b1;
                value = cdb1.data;
            end else if (cdb2.valid && (cdb2.rob_num == index)) begin
                ready = 1'b1;
                value = cdb2.data;
            end else if (busy[slot] && done[slot]) begin
                ready = 1'b1;
                value = data[slot];
            end
        end
    end

endmodule

// File: rtl/reorder_buffer.sv
// In-order reorder buffer: allocates tags at the tail, collects results from
// two broadcast ports and retires at most one completed entry per cycle.
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int unsigned          DEPTH       = ROB_DEPTH,
    parameter logic [ROB_NUM_W-1:0] INVALID_NUM = ROB_INVALID_NUM
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  alloc_valid,
    input  logic [ARCH_REG_W-1:0] alloc_dest,
    output logic                  alloc_ready,
    output logic [ROB_NUM_W-1:0]  alloc_robNum,
    input  logic                  CDBiscast,
    input  logic [ROB_NUM_W-1:0]  CDBrobNum,
    input  logic [DATA_W-1:0]     CDBdata,
    input  logic                  CDBiscast2,
    input  logic [ROB_NUM_W-1:0]  CDBrobNum2,
    input  logic [DATA_W-1:0]     CDBdata2,
    input  logic [ROB_NUM_W-1:0]  index,
    output logic                  ready,
    output logic [DATA_W-1:0]     value,
    output logic                  commit_valid,
    output logic [ROB_NUM_W-1:0]  commit_robNum,
    output logic [ARCH_REG_W-1:0] commit_dest,
    output logic [DATA_W-1:0]     commit_data,
    input  logic                  flush
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]                 busy;
    logic [DEPTH-1:0]                 done;
    logic [DEPTH-1:0][ARCH_REG_W-1:0] dest;
    logic [DEPTH-1:0][DATA_W-1:0]     data;
    logic [PTR_W-1:0]                 head;
    logic [PTR_W-1:0]                 tail;
    logic [CNT_W-1:0]                 count;

    cdb_t             cdb1;
    cdb_t             cdb2;
    logic [PTR_W-1:0] cdb1_slot;
    logic [PTR_W-1:0] cdb2_slot;
    logic             cdb1_hit;
    logic             cdb2_hit;
    logic             alloc_fire;
    logic             commit_fire;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign cdb1 = '{valid: CDBiscast,  rob_num: CDBrobNum,  data: CDBdata};
    assign cdb2 = '{valid: CDBiscast2, rob_num: CDBrobNum2, data: CDBdata2};

    assign cdb1_slot = PTR_W'(cdb1.rob_num);
    assign cdb2_slot = PTR_W'(cdb2.rob_num);

    // Broadcasts only land on entries that were already allocated before this edge.
    assign cdb1_hit = cdb1.valid && (cdb1.rob_num < ROB_NUM_W'(DEPTH)) && busy[cdb1_slot];
    assign cdb2_hit = cdb2.valid && (cdb2.rob_num < ROB_NUM_W'(DEPTH)) && busy[cdb2_slot];

    assign alloc_ready  = (count < CNT_W'(DEPTH));
    assign alloc_robNum = ROB_NUM_W'(tail);
    assign alloc_fire   = alloc_valid && alloc_ready;
    assign commit_fire  = busy[head] && done[head];

    rob_lookup #(
        .DEPTH (DEPTH)
    ) u_lookup (
        .index (index),
        .cdb1  (cdb1),
        .cdb2  (cdb2),
        .busy  (busy),
        .done  (done),
        .data  (data),
        .ready (ready),
        .value (value)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            busy          <= '0;
            done          <= '0;
            dest          <= '0;
            data          <= '0;
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            commit_valid  <= 1'b0;
            commit_robNum <= INVALID_NUM;
            commit_dest   <= '0;
            commit_data   <= '0;
        end else if (flush) begin
            busy         <= '0;
            done         <= '0;
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            commit_valid <= 1'b0;
        end else begin
            commit_valid <= commit_fire;
            if (commit_fire) begin
                commit_robNum <= ROB_NUM_W'(head);
                commit_dest   <= dest[head];
                commit_data   <= data[head];
                busy[head]    <= 1'b0;
                head          <= next_ptr(head);
            end
            // Port 2 is written first so port 1 overrides on a shared tag.
            if (cdb2_hit) begin
                done[cdb2_slot] <= 1'b1;
                data[cdb2_slot] <= cdb2.data;
            end
            if (cdb1_hit) begin
                done[cdb1_slot] <= 1'b1;
                data[cdb1_slot] <= cdb1.data;
            end
            if (alloc_fire) begin
                busy[tail] <= 1'b1;
                done[tail] <= 1'b0;
                dest[tail] <= alloc_dest;
                tail       <= next_ptr(tail);
            end
            case ({alloc_fire, commit_fire})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule
